// File: rtl/regfile_mp.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port register file for the pipelined processor. It replaces the old
// single-write / two-read register file.
//
//   * W0 : main-pipeline writeback.
//   * W1 : long-latency (mult/div) writeback. A W1 write also clears the busy
//          bit of its destination register.
//   * NR combinational read ports. When BYPASS = 1, a read returns the data
//     being written in the same cycle.
//   * Busy scoreboard, one bit per register. ctrl_setBusy sets the bit when a
//     mult/div operation issues. A W1 writeback clears it.
//   * err_waw is a sticky flag. It is set when W0 and W1 write the same live
//     register in the same cycle.
//
// Ports
//   clock          posedge clock for all state
//   ctrl_reset     asynchronous, active-high; clears registers, busy, err_waw
//   ctrl_we0/ctrl_wreg0/data_w0   W0 enable, destination, data
//   ctrl_we1/ctrl_wreg1/data_w1   W1 enable, destination, data
//   ctrl_setBusy/ctrl_busyReg     mark a register as pending
//   ctrl_readReg   NR packed read addresses; port k is at [k*AW +: AW]
//   data_readReg   NR packed read data; port k is at [k*W +: W]
//   busy_readReg   busy flag of each read address
//   data_rstatus   contents of STATUS_REG, using the same rules as a read port
//   err_waw        sticky same-cycle write-after-write collision flag
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int W          = 32,
    parameter int DEPTH      = 32,
    parameter int NR         = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int STATUS_REG = 30,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_we0,
    input  logic [AW-1:0]    ctrl_wreg0,
    input  logic [W-1:0]     data_w0,
    input  logic             ctrl_we1,
    input  logic [AW-1:0]    ctrl_wreg1,
    input  logic [W-1:0]     data_w1,
    input  logic             ctrl_setBusy,
    input  logic [AW-1:0]    ctrl_busyReg,
    input  logic [NR*AW-1:0] ctrl_readReg,
    output logic [NR*W-1:0]  data_readReg,
    output logic [NR-1:0]    busy_readReg,
    output logic [W-1:0]     data_rstatus,
    output logic             err_waw
);

    // The status tap only exists if STATUS_REG lies inside the file.
    localparam bit STATUS_VALID = (STATUS_REG >= 0) && (STATUS_REG < DEPTH);

    // An address is dropped if it is the hard-wired zero register or if it is
    // past the end of a file whose depth is not a power of two.
    function automatic logic is_dropped(input logic [AW-1:0] a);
        return ((ZERO_REG != 0) && (a == '0)) || (int'({1'b0, a}) >= DEPTH);
    endfunction

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [W-1:0]     store_reg [DEPTH];
    logic [DEPTH-1:0] busy_reg;
    logic             err_waw_reg;

    // Qualified write/set strobes. A strobe is not qualified if its target is dropped.
    logic w0_ok;
    logic w1_ok;
    logic set_ok;

    assign w0_ok  = ctrl_we0     && !is_dropped(ctrl_wreg0);
    assign w1_ok  = ctrl_we1     && !is_dropped(ctrl_wreg1);
    assign set_ok = ctrl_setBusy && !is_dropped(ctrl_busyReg);

    // Bypass sources are masked while reset is held. The write cannot land,
    // so the read ports must show the cleared file rather than in-flight data.
    logic w0_byp;
    logic w1_byp;

    assign w0_byp = w0_ok && !ctrl_reset;
    assign w1_byp = w1_ok && !ctrl_reset;

    // One-hot decode of each strobe. Every register then updates from its own hit bits.
    logic [DEPTH-1:0] w0_hit;
    logic [DEPTH-1:0] w1_hit;
    logic [DEPTH-1:0] set_hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
            assign w0_hit[gi]  = w0_ok  && (ctrl_wreg0   == AW'(gi));
            assign w1_hit[gi]  = w1_ok  && (ctrl_wreg1   == AW'(gi));
            assign set_hit[gi] = set_ok && (ctrl_busyReg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_reg[i] <= '0;
            end
            busy_reg    <= '0;
            err_waw_reg <= 1'b0;
        end else begin
            // W0 has priority over W1 when both target the same register.
            for (int i = 0; i < DEPTH; i++) begin
                if (w0_hit[i]) begin
                    store_reg[i] <= data_w0;
                end else if (w1_hit[i]) begin
                    store_reg[i] <= data_w1;
                end
            end
            // A same-edge set and clear is treated as a new issue, so the set wins.
            // W0 writes leave busy untouched.
            busy_reg <= set_hit | (busy_reg & ~w1_hit);
            if (w0_ok && w1_ok && (ctrl_wreg0 == ctrl_wreg1)) begin
                err_waw_reg <= 1'b1;
            end
        end
    end

    assign err_waw = err_waw_reg;

    // -------------------------------------------------------------------------
    // Read ports. Index NR is the status tap: it has the same data path as a
    // read port, but no busy output.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi <= NR; gi++) begin : g_read
            logic [AW-1:0] addr;
            logic          addr_valid;
            logic [W-1:0]  rdata;

            if (gi < NR) begin : g_port_addr
                assign addr       = ctrl_readReg[gi*AW +: AW];
                assign addr_valid = !is_dropped(addr);
            end else begin : g_status_addr
                assign addr       = AW'(STATUS_REG);
                assign addr_valid = STATUS_VALID && !is_dropped(addr);
            end

            always_comb begin
                rdata = '0;
                if (addr_valid) begin
                    if ((BYPASS != 0) && w0_byp && (ctrl_wreg0 == addr)) begin
                        rdata = data_w0;
                    end else if ((BYPASS != 0) && w1_byp && (ctrl_wreg1 == addr)) begin
                        rdata = data_w1;
                    end else begin
                        rdata = store_reg[addr];
                    end
                end
            end

            if (gi < NR) begin : g_port_out
                logic clr_pending;
                logic set_pending;
                logic busy;

                // A W1 writeback in this cycle releases the register early.
                // The exception is a fresh issue to the same register.
                // A set in the same cycle is not itself visible to the read port.
                assign clr_pending = (BYPASS != 0) && w1_byp && (ctrl_wreg1 == addr);
                assign set_pending = set_ok && (ctrl_busyReg == addr);

                always_comb begin
                    busy = 1'b0;
                    if (addr_valid) begin
                        busy = busy_reg[addr] && !(clr_pending && !set_pending);
                    end
                end

                assign data_readReg[gi*W +: W] = rdata;
                assign busy_readReg[gi]        = busy;
            end else begin : g_status_out
                assign data_rstatus = rdata;
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp with default parameters. There are two
// instances with shared inputs: dut (BYPASS=1) and dut_nb (BYPASS=0).
// The reference model is an array-based architectural view of the register
// file, busy bits and error flag. Expected outputs are derived from that view
// and from the current-cycle writes.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clock;
    logic             ctrl_reset;
    logic             ctrl_we0;
    logic [AW-1:0]    ctrl_wreg0;
    logic [W-1:0]     data_w0;
    logic             ctrl_we1;
    logic [AW-1:0]    ctrl_wreg1;
    logic [W-1:0]     data_w1;
    logic             ctrl_setBusy;
    logic [AW-1:0]    ctrl_busyReg;
    logic [NR*AW-1:0] ctrl_readReg;

    logic [NR*W-1:0]  data_readReg;
    logic [NR-1:0]    busy_readReg;
    logic [W-1:0]     data_rstatus;
    logic             err_waw;

    logic [NR*W-1:0]  nb_data_readReg;
    logic [NR-1:0]    nb_busy_readReg;
    logic [W-1:0]     nb_data_rstatus;
    logic             nb_err_waw;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: architectural state only.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_err;

    regfile_mp #(.BYPASS(1)) dut (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .ctrl_we0     (ctrl_we0),
        .ctrl_wreg0   (ctrl_wreg0),
        .data_w0      (data_w0),
        .ctrl_we1     (ctrl_we1),
        .ctrl_wreg1   (ctrl_wreg1),
        .data_w1      (data_w1),
        .ctrl_setBusy (ctrl_setBusy),
        .ctrl_busyReg (ctrl_busyReg),
        .ctrl_readReg (ctrl_readReg),
        .data_readReg (data_readReg),
        .busy_readReg (busy_readReg),
        .data_rstatus (data_rstatus),
        .err_waw      (err_waw)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .ctrl_we0     (ctrl_we0),
        .ctrl_wreg0   (ctrl_wreg0),
        .data_w0      (data_w0),
        .ctrl_we1     (ctrl_we1),
        .ctrl_wreg1   (ctrl_wreg1),
        .data_w1      (data_w1),
        .ctrl_setBusy (ctrl_setBusy),
        .ctrl_busyReg (ctrl_busyReg),
        .ctrl_readReg (ctrl_readReg),
        .data_readReg (nb_data_readReg),
        .busy_readReg (nb_busy_readReg),
        .data_rstatus (nb_data_rstatus),
        .err_waw      (nb_err_waw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Expected read data: register 0 is hard zero. With bypass, the value
    // being written this cycle is visible, and W0 wins over W1.
    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (ctrl_reset || a == 5'd0) return 32'h0;
        if (byp && ctrl_we0 && ctrl_wreg0 != 5'd0 && ctrl_wreg0 == a) return data_w0;
        if (byp && ctrl_we1 && ctrl_wreg1 != 5'd0 && ctrl_wreg1 == a) return data_w1;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (ctrl_reset || a == 5'd0) return 1'b0;
        if (byp && ctrl_we1 && ctrl_wreg1 == a && !(ctrl_setBusy && ctrl_busyReg == a))
            return 1'b0;
        return m_busy[a];
    endfunction

    // Architectural effect of one clock edge, applied in priority order.
    task automatic model_update();
        if (ctrl_reset) return;
        if (ctrl_we1 && ctrl_wreg1 != 5'd0) begin
            m_regs[ctrl_wreg1] = data_w1;
            m_busy[ctrl_wreg1] = 1'b0;
        end
        if (ctrl_we0 && ctrl_wreg0 != 5'd0) m_regs[ctrl_wreg0] = data_w0;
        if (ctrl_setBusy && ctrl_busyReg != 5'd0) m_busy[ctrl_busyReg] = 1'b1;
        if (ctrl_we0 && ctrl_we1 && ctrl_wreg0 != 5'd0 && ctrl_wreg0 == ctrl_wreg1)
            m_err = 1'b1;
    endtask

    task automatic compare_all(input string tag);
        for (int p = 0; p < NR; p++) begin
            logic [4:0] a;
            a = ctrl_readReg[p*AW +: AW];
            check($sformatf("%s_p%0d_data", tag, p), data_readReg[p*W +: W], exp_data(a, 1'b1));
            check($sformatf("%s_p%0d_busy", tag, p), 32'(busy_readReg[p]), 32'(exp_busy(a, 1'b1)));
            check($sformatf("%s_p%0d_nbdata", tag, p), nb_data_readReg[p*W +: W], exp_data(a, 1'b0));
            check($sformatf("%s_p%0d_nbbusy", tag, p), 32'(nb_busy_readReg[p]), 32'(exp_busy(a, 1'b0)));
        end
        check({tag, "_status"},   data_rstatus,    exp_data(5'd30, 1'b1));
        check({tag, "_nbstatus"}, nb_data_rstatus, exp_data(5'd30, 1'b0));
        check({tag, "_err"},      32'(err_waw),    32'(m_err));
        check({tag, "_nberr"},    32'(nb_err_waw), 32'(m_err));
    endtask

    // Inputs are driven 1ns after a posedge. Outputs are sampled 2ns later.
    task automatic settle_check(input string tag);
        #2;
        compare_all(tag);
        $display("[TB] %s rst=%0d we0=%0d r%0d=%h we1=%0d r%0d=%h set=%0d r%0d rd=%0d/%0d",
                 tag, ctrl_reset, ctrl_we0, ctrl_wreg0, data_w0, ctrl_we1, ctrl_wreg1, data_w1,
                 ctrl_setBusy, ctrl_busyReg, ctrl_readReg[4:0], ctrl_readReg[9:5]);
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle();
        ctrl_we0 = 0; ctrl_wreg0 = '0; data_w0 = '0;
        ctrl_we1 = 0; ctrl_wreg1 = '0; data_w1 = '0;
        ctrl_setBusy = 0; ctrl_busyReg = '0;
    endtask

    initial begin
        idle();
        ctrl_readReg = '0;
        ctrl_reset   = 1'b1;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        ctrl_reset = 1'b0;

        // Reset state
        ctrl_readReg = {5'd30, 5'd5};
        settle_check("reset");
        advance();

        // 1: W0 write, then read back
        ctrl_we0 = 1; ctrl_wreg0 = 5'd5; data_w0 = 32'hDEADBEEF;
        settle_check("t1_wr");
        advance();
        idle();
        ctrl_readReg = {5'd5, 5'd5};
        settle_check("t1_rd");
        check("t1_data0", data_readReg[31:0], 32'hDEADBEEF);
        check("t1_data1", data_readReg[63:32], 32'hDEADBEEF);
        check("t1_busy", 32'(busy_readReg), 32'h0);
        advance();

        // 2: writes to r0 are dropped
        ctrl_we0 = 1; ctrl_wreg0 = 5'd0; data_w0 = 32'h1234;
        ctrl_we1 = 1; ctrl_wreg1 = 5'd0; data_w1 = 32'h1234;
        ctrl_readReg = {5'd0, 5'd0};
        settle_check("t2_wr");
        advance();
        idle();
        settle_check("t2_rd");
        check("t2_r0", data_readReg[31:0], 32'h0);
        check("t2_err", 32'(err_waw), 32'h0);
        advance();

        // 3: W0/W1 collision on r7
        ctrl_we0 = 1; ctrl_wreg0 = 5'd7; data_w0 = 32'hAAAA0000;
        ctrl_we1 = 1; ctrl_wreg1 = 5'd7; data_w1 = 32'h5555;
        ctrl_readReg = {5'd7, 5'd7};
        settle_check("t3_wr");
        advance();
        idle();
        for (int i = 0; i < 3; i++) begin
            settle_check("t3_rd");
            check("t3_r7", data_readReg[31:0], 32'hAAAA0000);
            check("t3_err", 32'(err_waw), 32'h1);
            advance();
        end

        // 4: busy scoreboard on r9
        ctrl_setBusy = 1; ctrl_busyReg = 5'd9;
        ctrl_readReg = {5'd9, 5'd9};
        settle_check("t4_set");
        check("t4_set_invisible", 32'(busy_readReg[0]), 32'h0);
        advance();
        idle();
        for (int i = 0; i < 10; i++) begin
            settle_check("t4_hold");
            check("t4_busy_hold", 32'(busy_readReg[0]), 32'h1);
            advance();
        end
        ctrl_we1 = 1; ctrl_wreg1 = 5'd9; data_w1 = 32'd42;
        settle_check("t4_wb");
        check("t4_wb_busy", 32'(busy_readReg[0]), 32'h0);
        check("t4_wb_data", data_readReg[31:0], 32'd42);
        check("t4_wb_nbbusy", 32'(nb_busy_readReg[0]), 32'h1);
        check("t4_wb_nbdata", nb_data_readReg[31:0], 32'h0);
        advance();
        idle();
        settle_check("t4_after");
        check("t4_after_data", data_readReg[31:0], 32'd42);
        check("t4_after_busy", 32'(busy_readReg[0]), 32'h0);
        advance();

        // 5: same-cycle bypass of r3
        ctrl_we0 = 1; ctrl_wreg0 = 5'd3; data_w0 = 32'h77;
        ctrl_readReg = {5'd3, 5'd3};
        settle_check("t5");
        check("t5_byp", data_readReg[31:0], 32'h77);
        check("t5_nobyp", nb_data_readReg[31:0], 32'h0);
        advance();
        idle();

        // Randomized traffic, biased toward a few registers to force collisions
        for (int n = 0; n < 400; n++) begin
            ctrl_reset = ($urandom_range(0, 63) == 0);
            if (ctrl_reset) model_clear();
            ctrl_we0 = $urandom_range(0, 1);
            ctrl_wreg0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            data_w0 = $urandom;
            ctrl_we1 = ($urandom_range(0, 2) == 0);
            ctrl_wreg1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            data_w1 = $urandom;
            ctrl_setBusy = ($urandom_range(0, 3) == 0);
            ctrl_busyReg = 5'($urandom_range(0, 7));
            ctrl_readReg[4:0] = ($urandom_range(0, 4) == 0) ? 5'd30 : 5'($urandom_range(0, 7));
            ctrl_readReg[9:5] = 5'($urandom);
            if ($urandom_range(0, 3) == 0) ctrl_readReg[9:5] = ctrl_readReg[4:0];
            if ($urandom_range(0, 5) == 0) ctrl_wreg0 = 5'd30;
            settle_check("rand");
            advance();
        end
        ctrl_reset = 1'b0;
        idle();

        // 6: fill r1..r31, then assert reset between edges
        for (int i = 1; i < 32; i++) begin
            ctrl_we0 = 1; ctrl_wreg0 = 5'(i); data_w0 = 32'(i);
            ctrl_setBusy = 1; ctrl_busyReg = 5'(i);
            ctrl_readReg = {5'(i), 5'(i - 1)};
            settle_check("t6_fill");
            advance();
        end
        ctrl_we0 = 1; ctrl_wreg0 = 5'd5; data_w0 = 32'hFFFF;
        ctrl_setBusy = 0;
        ctrl_readReg = {5'd30, 5'd5};
        #2;
        check("t6_pre_r30", data_readReg[63:32], 32'd30);
        ctrl_reset = 1'b1;
        model_clear();
        #1;
        check("t6_rst_status", data_rstatus, 32'h0);
        check("t6_rst_r5", data_readReg[31:0], 32'h0);
        check("t6_rst_err", 32'(err_waw), 32'h0);
        @(posedge clock);
        #1;
        for (int a = 0; a < 32; a += 2) begin
            ctrl_readReg = {5'(a + 1), 5'(a)};
            settle_check("t6_rst");
            check("t6_rst_busy", 32'(busy_readReg), 32'h0);
            advance();
        end
        ctrl_reset = 1'b0;
        idle();
        ctrl_readReg = {5'd31, 5'd5};
        settle_check("t6_post");
        check("t6_post_r5", data_readReg[31:0], 32'h0);
        advance();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
